// File: rtl/cpu_pkg.sv
// Shared CPU constants and the types used by the hazard controller.
package cpu_pkg;

   localparam int XLEN      = 32;
   localparam int REG_IDX_W = 5;

   localparam logic [1:0] WB_ALU  = 2'd0;
   localparam logic [1:0] WB_DRAM = 2'd1;
   localparam logic [1:0] WB_PC4  = 2'd2;
   localparam logic [1:0] WB_EXT  = 2'd3;

   typedef struct packed {
      logic [REG_IDX_W-1:0] wr;
      logic                 we;
      logic                 is_load;
   } shadow_entry_t;

   localparam shadow_entry_t BUBBLE = '{wr: '0, we: 1'b0, is_load: 1'b0};

   typedef enum logic [1:0] {RUN, STALL, FLUSH} hz_state_t;

   // An entry produces a value for idx only if it actually writes that register.
   function automatic logic hits(input shadow_entry_t ent, input logic [REG_IDX_W-1:0] idx);
      return ent.we && (ent.wr == idx);
   endfunction

endpackage

// File: rtl/hz_shadow.sv
// Shadow copy of the destination info for the EX, MEM and WB stages.
module hz_shadow
   import cpu_pkg::*;
(
   input  logic                 clk,
   input  logic                 rst,
   input  logic [REG_IDX_W-1:0] wr_in,
   input  logic                 we_in,
   input  logic [1:0]           wbsel_in,
   input  logic                 bubble,
   output shadow_entry_t        sh_ex,
   output shadow_entry_t        sh_mem,
   output shadow_entry_t        sh_wb
);

   always_ff @(posedge clk) begin
      if (rst) begin
         sh_ex  <= BUBBLE;
         sh_mem <= BUBBLE;
         sh_wb  <= BUBBLE;
      end else begin
         sh_wb  <= sh_mem;
         sh_mem <= sh_ex;
         sh_ex  <= bubble ? BUBBLE
                          : '{wr: wr_in, we: we_in, is_load: (wbsel_in == WB_DRAM)};
      end
   end

endmodule

// File: rtl/hazard_ctrl.sv
// Forwarding, load-use stall and branch flush control.
// Define HAZ_PERF_EN to add the saturating stall_cnt/flush_cnt counters.
module hazard_ctrl
   import cpu_pkg::*;
(
   input  logic                 clk,
   input  logic                 rst,
   input  logic [REG_IDX_W-1:0] rR1_ID,
   input  logic [REG_IDX_W-1:0] rR2_ID,
   input  logic                 rR1_used,
   input  logic                 rR2_used,
   input  logic [REG_IDX_W-1:0] wR_ID,
   input  logic                 RF_we_ID,
   input  logic [1:0]           WBsel_ID,
   input  logic                 npc_op_EX,
   input  logic [XLEN-1:0]      wD_EX,
   input  logic [XLEN-1:0]      wD_MEM,
   input  logic [XLEN-1:0]      wD_WB,
   output logic [XLEN-1:0]      rD1_fw,
   output logic [XLEN-1:0]      rD2_fw,
   output logic                 rD1_fw_op,
   output logic                 rD2_fw_op,
   output logic                 flush_ID_EX,
   output logic                 flush_IF_ID,
   output logic                 stall_PC,
   output logic                 stall_IF_ID
`ifdef HAZ_PERF_EN
   ,
   output logic [31:0]          stall_cnt,
   output logic [31:0]          flush_cnt
`endif
);

   shadow_entry_t sh_ex, sh_mem, sh_wb;
   hz_state_t     state, state_next;
   logic          load_use, stall_now;
   logic [XLEN:0] pick1, pick2;

   hz_shadow u_shadow (
      .clk      (clk),
      .rst      (rst),
      .wr_in    (wR_ID),
      .we_in    (RF_we_ID),
      .wbsel_in (WBsel_ID),
      .bubble   (flush_ID_EX),
      .sh_ex    (sh_ex),
      .sh_mem   (sh_mem),
      .sh_wb    (sh_wb)
   );

   // Only the EX entry's load flag matters; older loads have their data by then.
   logic unused_load_bits;
   assign unused_load_bits = sh_mem.is_load ^ sh_wb.is_load;

   function automatic logic [XLEN:0] fwd_pick(
      input logic                 used,
      input logic [REG_IDX_W-1:0] idx,
      input logic                 ex_ok,
      input shadow_entry_t        ex_ent,
      input shadow_entry_t        mem_ent,
      input shadow_entry_t        wb_ent,
      input logic [XLEN-1:0]      d_ex,
      input logic [XLEN-1:0]      d_mem,
      input logic [XLEN-1:0]      d_wb
   );
      fwd_pick = '0;
      if (used && idx != '0) begin
         if (ex_ok && hits(ex_ent, idx))  fwd_pick = {1'b1, d_ex};
         else if (hits(mem_ent, idx))     fwd_pick = {1'b1, d_mem};
         else if (hits(wb_ent, idx))      fwd_pick = {1'b1, d_wb};
      end
   endfunction

   always_ff @(posedge clk) begin
      if (rst) state <= RUN;
      else     state <= state_next;
   end

   // A load in EX cannot forward its data yet, so its EX match is suppressed.
   always_comb begin
      load_use    = 1'b0;
      stall_now   = 1'b0;
      state_next  = RUN;
      flush_ID_EX = 1'b0;
      flush_IF_ID = 1'b0;
      stall_PC    = 1'b0;
      stall_IF_ID = 1'b0;
      rD1_fw_op   = 1'b0;
      rD2_fw_op   = 1'b0;
      rD1_fw      = '0;
      rD2_fw      = '0;
      pick1       = '0;
      pick2       = '0;

      load_use  = sh_ex.is_load && sh_ex.we && (sh_ex.wr != '0) &&
                  ((rR1_used && rR1_ID == sh_ex.wr) || (rR2_used && rR2_ID == sh_ex.wr));
      stall_now = load_use && !npc_op_EX && (state != STALL);

      if (npc_op_EX)      state_next = FLUSH;
      else if (stall_now) state_next = STALL;

      pick1 = fwd_pick(rR1_used, rR1_ID, !load_use, sh_ex, sh_mem, sh_wb, wD_EX, wD_MEM, wD_WB);
      pick2 = fwd_pick(rR2_used, rR2_ID, !load_use, sh_ex, sh_mem, sh_wb, wD_EX, wD_MEM, wD_WB);

      if (!rst) begin
         flush_ID_EX = npc_op_EX || stall_now;
         flush_IF_ID = npc_op_EX;
         stall_PC    = stall_now;
         stall_IF_ID = stall_now;
         rD1_fw_op   = pick1[XLEN];
         rD1_fw      = pick1[XLEN-1:0];
         rD2_fw_op   = pick2[XLEN];
         rD2_fw      = pick2[XLEN-1:0];
      end
   end

   // A stall always bubbles EX, so a second load-use right after one cannot occur.
   always_ff @(posedge clk) begin
      if (!rst) assert (!(state == STALL && load_use));
   end

`ifdef HAZ_PERF_EN
   logic [31:0] stall_q, flush_q;

   always_ff @(posedge clk) begin
      if (rst) begin
         stall_q <= '0;
         flush_q <= '0;
      end else begin
         if (stall_PC && stall_q != 32'hFFFF_FFFF)    stall_q <= stall_q + 32'd1;
         if (flush_IF_ID && flush_q != 32'hFFFF_FFFF) flush_q <= flush_q + 32'd1;
      end
   end

   assign stall_cnt = rst ? '0 : stall_q;
   assign flush_cnt = rst ? '0 : flush_q;
`endif

endmodule

// File: tb/tb_hazard_ctrl.sv
// Self-checking bench for hazard_ctrl: directed scenarios then random traffic vs a model.
module tb_hazard_ctrl;
   import cpu_pkg::*;

   logic        clk = 1'b0;
   logic        rst;
   logic [4:0]  rR1_ID, rR2_ID, wR_ID;
   logic        rR1_used, rR2_used, RF_we_ID, npc_op_EX;
   logic [1:0]  WBsel_ID;
   logic [31:0] wD_EX, wD_MEM, wD_WB;
   logic [31:0] rD1_fw, rD2_fw;
   logic        rD1_fw_op, rD2_fw_op, flush_ID_EX, flush_IF_ID, stall_PC, stall_IF_ID;
`ifdef HAZ_PERF_EN
   logic [31:0] stall_cnt, flush_cnt;
   logic [31:0] savedStall, savedFlush;
`endif

   always #5 clk = ~clk;

   hazard_ctrl dut (
      .clk         (clk),
      .rst         (rst),
      .rR1_ID      (rR1_ID),
      .rR2_ID      (rR2_ID),
      .rR1_used    (rR1_used),
      .rR2_used    (rR2_used),
      .wR_ID       (wR_ID),
      .RF_we_ID    (RF_we_ID),
      .WBsel_ID    (WBsel_ID),
      .npc_op_EX   (npc_op_EX),
      .wD_EX       (wD_EX),
      .wD_MEM      (wD_MEM),
      .wD_WB       (wD_WB),
      .rD1_fw      (rD1_fw),
      .rD2_fw      (rD2_fw),
      .rD1_fw_op   (rD1_fw_op),
      .rD2_fw_op   (rD2_fw_op),
      .flush_ID_EX (flush_ID_EX),
      .flush_IF_ID (flush_IF_ID),
      .stall_PC    (stall_PC),
      .stall_IF_ID (stall_IF_ID)
`ifdef HAZ_PERF_EN
      ,
      .stall_cnt   (stall_cnt),
      .flush_cnt   (flush_cnt)
`endif
   );

   // Reference model: last three issued writers, index 0 = youngest (EX).
   logic [4:0]  mWr [3] = '{5'd0, 5'd0, 5'd0};
   logic        mWe [3] = '{1'b0, 1'b0, 1'b0};
   logic        mLd [3] = '{1'b0, 1'b0, 1'b0};
   hz_state_t   mState = RUN;
   logic [31:0] mStallCnt = '0, mFlushCnt = '0;
   logic        expStall, expFlushIdEx;

   int checkCount = 0, passCount = 0, failCount = 0;

   task automatic checkVal(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checkCount++;
      assert (obs === exp) passCount++;
      else begin
         failCount++;
         $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic applyStimulus(input logic r, input logic [4:0] r1, input logic u1,
                                input logic [4:0] r2, input logic u2, input logic [4:0] wr,
                                input logic we, input logic [1:0] wbsel, input logic npc,
                                input logic [31:0] dEx, input logic [31:0] dMem, input logic [31:0] dWb);
      rst = r; rR1_ID = r1; rR1_used = u1; rR2_ID = r2; rR2_used = u2;
      wR_ID = wr; RF_we_ID = we; WBsel_ID = wbsel; npc_op_EX = npc;
      wD_EX = dEx; wD_MEM = dMem; wD_WB = dWb;
      #1;
   endtask

   task automatic modelForward(input logic used, input logic [4:0] idx, input logic skipEx,
                               output logic op, output logic [31:0] val);
      logic [31:0] stageData [3];
      stageData = '{wD_EX, wD_MEM, wD_WB};
      op = 1'b0;
      val = '0;
      if (used && idx != 5'd0) begin
         for (int k = 0; k < 3; k++) begin
            if (!op && !(k == 0 && skipEx) && mWe[k] && mWr[k] == idx) begin
               op = 1'b1;
               val = stageData[k];
            end
         end
      end
   endtask

   task automatic checkOutput();
      logic luRaw, op1, op2;
      logic [31:0] v1, v2;
      luRaw = mLd[0] && mWe[0] && mWr[0] != 5'd0 &&
              ((rR1_used && rR1_ID == mWr[0]) || (rR2_used && rR2_ID == mWr[0]));
      expStall     = luRaw && !npc_op_EX && mState != STALL;
      expFlushIdEx = npc_op_EX || expStall;
      modelForward(rR1_used, rR1_ID, luRaw, op1, v1);
      modelForward(rR2_used, rR2_ID, luRaw, op2, v2);
      if (rst) begin
         op1 = 0; op2 = 0; v1 = 0; v2 = 0;
      end
      checkVal("rD1_fw_op",   32'(rD1_fw_op),   32'(op1));
      checkVal("rD1_fw",      rD1_fw,           v1);
      checkVal("rD2_fw_op",   32'(rD2_fw_op),   32'(op2));
      checkVal("rD2_fw",      rD2_fw,           v2);
      checkVal("flush_ID_EX", 32'(flush_ID_EX), 32'(!rst && expFlushIdEx));
      checkVal("flush_IF_ID", 32'(flush_IF_ID), 32'(!rst && npc_op_EX));
      checkVal("stall_PC",    32'(stall_PC),    32'(!rst && expStall));
      checkVal("stall_IF_ID", 32'(stall_IF_ID), 32'(!rst && expStall));
`ifdef HAZ_PERF_EN
      checkVal("stall_cnt", stall_cnt, rst ? 32'd0 : mStallCnt);
      checkVal("flush_cnt", flush_cnt, rst ? 32'd0 : mFlushCnt);
`endif
   endtask

   task automatic advance();
      @(posedge clk);
      if (rst) begin
         mWr = '{5'd0, 5'd0, 5'd0};
         mWe = '{1'b0, 1'b0, 1'b0};
         mLd = '{1'b0, 1'b0, 1'b0};
         mState = RUN;
         mStallCnt = '0;
         mFlushCnt = '0;
      end else begin
         for (int k = 2; k > 0; k--) begin
            mWr[k] = mWr[k-1]; mWe[k] = mWe[k-1]; mLd[k] = mLd[k-1];
         end
         mWr[0] = expFlushIdEx ? 5'd0 : wR_ID;
         mWe[0] = expFlushIdEx ? 1'b0 : RF_we_ID;
         mLd[0] = expFlushIdEx ? 1'b0 : (WBsel_ID == WB_DRAM);
         if (expStall && mStallCnt != 32'hFFFF_FFFF)  mStallCnt++;
         if (npc_op_EX && mFlushCnt != 32'hFFFF_FFFF) mFlushCnt++;
         mState = npc_op_EX ? FLUSH : (expStall ? STALL : RUN);
      end
      @(negedge clk);
      checkVal("fsm_state", 32'(dut.state), 32'(mState));
   endtask

   task automatic cycle();
      checkOutput();
      advance();
   endtask

   initial begin
      @(negedge clk);
      applyStimulus(1, 5'd1, 1, 5'd2, 1, 5'd1, 1, WB_DRAM, 1, 32'h11, 32'h22, 32'h33);
      cycle();
      cycle();

      // EX forward of an ALU result
      applyStimulus(0, 0, 0, 0, 0, 5'd5, 1, WB_ALU, 0, 0, 0, 0);
      cycle();
      applyStimulus(0, 5'd5, 1, 0, 0, 0, 0, WB_ALU, 0, 32'h1234, 32'h5, 32'h6);
      checkVal("ex_fwd_op",  32'(rD1_fw_op), 32'd1);
      checkVal("ex_fwd_val", rD1_fw, 32'h1234);
      checkVal("ex_fwd_nostall", 32'(stall_PC), 32'd0);
      cycle();

      // EX beats MEM when both write the same register
      applyStimulus(0, 0, 0, 0, 0, 5'd7, 1, WB_ALU, 0, 0, 0, 0);
      cycle();
      applyStimulus(0, 0, 0, 0, 0, 5'd7, 1, WB_PC4, 0, 0, 0, 0);
      cycle();
      applyStimulus(0, 0, 0, 5'd7, 1, 0, 0, WB_ALU, 0, 32'hA, 32'hB, 32'hC);
      checkVal("prio_val", rD2_fw, 32'hA);
      cycle();

      // x0 never forwards
      applyStimulus(0, 0, 0, 0, 0, 5'd0, 1, WB_ALU, 0, 0, 0, 0);
      cycle();
      applyStimulus(0, 5'd0, 1, 0, 0, 0, 0, WB_ALU, 0, 32'h99, 32'h98, 32'h97);
      checkVal("x0_op", 32'(rD1_fw_op), 32'd0);
      checkVal("x0_nostall", 32'(stall_PC), 32'd0);
      cycle();

      // load-use: one stall cycle, then the MEM forward
      applyStimulus(0, 0, 0, 0, 0, 5'd3, 1, WB_DRAM, 0, 0, 0, 0);
      cycle();
      applyStimulus(0, 5'd3, 1, 0, 0, 0, 0, WB_ALU, 0, 32'h1, 32'hBEEF, 32'h2);
      checkVal("lu_stall_pc", 32'(stall_PC), 32'd1);
      checkVal("lu_stall_ifid", 32'(stall_IF_ID), 32'd1);
      checkVal("lu_flush_idex", 32'(flush_ID_EX), 32'd1);
      cycle();
      applyStimulus(0, 5'd3, 1, 0, 0, 0, 0, WB_ALU, 0, 32'h1, 32'hBEEF, 32'h2);
      checkVal("lu_after_stall", 32'(stall_PC), 32'd0);
      checkVal("lu_mem_op", 32'(rD1_fw_op), 32'd1);
      checkVal("lu_mem_val", rD1_fw, 32'hBEEF);
      cycle();

      // branch together with load-use: flush wins, no stall
      applyStimulus(0, 0, 0, 0, 0, 5'd3, 1, WB_DRAM, 0, 0, 0, 0);
      cycle();
      applyStimulus(0, 5'd3, 1, 0, 0, 0, 0, WB_ALU, 1, 0, 0, 0);
`ifdef HAZ_PERF_EN
      savedStall = stall_cnt;
      savedFlush = flush_cnt;
`endif
      checkVal("col_flush_ifid", 32'(flush_IF_ID), 32'd1);
      checkVal("col_flush_idex", 32'(flush_ID_EX), 32'd1);
      checkVal("col_stall", 32'(stall_PC), 32'd0);
      cycle();
      checkVal("col_state", 32'(dut.state), 32'(FLUSH));
`ifdef HAZ_PERF_EN
      checkVal("col_flush_cnt", flush_cnt, savedFlush + 32'd1);
      checkVal("col_stall_cnt", stall_cnt, savedStall);
`endif

      // reset during a stall cycle abandons it
      applyStimulus(0, 0, 0, 0, 0, 5'd4, 1, WB_DRAM, 0, 0, 0, 0);
      cycle();
      applyStimulus(0, 5'd4, 1, 0, 0, 0, 0, WB_ALU, 0, 32'h7, 32'h8, 32'h9);
      checkVal("rst_pre_stall", 32'(stall_PC), 32'd1);
      applyStimulus(1, 5'd4, 1, 0, 0, 0, 0, WB_ALU, 0, 32'h7, 32'h8, 32'h9);
      checkVal("rst_stall_held", 32'(stall_PC), 32'd0);
      cycle();
      applyStimulus(0, 5'd4, 1, 0, 0, 0, 0, WB_ALU, 0, 32'h7, 32'h8, 32'h9);
      checkVal("rst_after_op", 32'(rD1_fw_op), 32'd0);
      checkVal("rst_after_stall", 32'(stall_PC), 32'd0);
      checkVal("rst_after_state", 32'(dut.state), 32'(RUN));
      cycle();

      // random traffic over a small register range so hazards are frequent
      for (int n = 0; n < 400; n++) begin
         applyStimulus($urandom_range(0, 39) == 0,
                       5'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
                       5'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
                       5'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
                       2'($urandom_range(0, 3)), $urandom_range(0, 7) == 0,
                       $urandom, $urandom, $urandom);
         cycle();
      end

      $display("%0d/%0d checks passed", passCount, checkCount);
      $finish;
   end

endmodule
